// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with 3-sample majority voting, optional parity and
// second stop bit, error/overrun pulses and a one-entry valid/ready holding register.
// Define UART_RX_BREAK_DET_EN to enable break detection (break_det plus a wait-for-idle state).
module uart_rx_cfg #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned PRESCALE_W  = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic [DATA_W-1:0]     P_DATA,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  overrun,
    output logic                  break_det,
    output logic                  busy
);

    localparam int unsigned BitCntW = $clog2(DATA_W);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2,
        StWaitIdle
    } state_e;

    state_e                  state_q;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [PRESCALE_W-1:0]   presc_q;
    logic [PRESCALE_W-1:0]   edge_cnt_q;
    logic [BitCntW-1:0]      bit_cnt_q;
    logic [DATA_W-1:0]       shift_q;
    logic                    s1_q, s2_q;
    logic                    par_en_q, par_typ_q, stop2_q;
    logic                    par_bad_q, stp_bad_q, done_q;
`ifdef UART_RX_BREAK_DET_EN
    logic                    all_zero_q, brk_q;
`endif

    logic                    rx_s, maj;
    logic                    at_s1, at_s2, at_s3, at_end;
    logic [PRESCALE_W-1:0]   half, presc_in;

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign half = {1'b0, presc_q[PRESCALE_W-1:1]};

    assign at_s1  = (edge_cnt_q == half - PRESCALE_W'(1));
    assign at_s2  = (edge_cnt_q == half);
    assign at_s3  = (edge_cnt_q == half + PRESCALE_W'(1));
    assign at_end = (edge_cnt_q == presc_q - PRESCALE_W'(1));

    // Third sample is taken live so the vote lands on the P/2+1 edge itself.
    assign maj = (s1_q & s2_q) | (s1_q & rx_s) | (s2_q & rx_s);

    always_comb begin
        presc_in = {Prescale[PRESCALE_W-1:1], 1'b0};
        if (Prescale < PRESCALE_W'(8)) begin
            presc_in = PRESCALE_W'(8);
        end
    end

`ifndef UART_RX_BREAK_DET_EN
    assign break_det = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            sync_q     <= '1;
            presc_q    <= PRESCALE_W'(8);
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            par_bad_q  <= 1'b0;
            stp_bad_q  <= 1'b0;
            done_q     <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            all_zero_q <= 1'b0;
            brk_q      <= 1'b0;
            break_det  <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], RX_IN};
            par_err <= 1'b0;
            stp_err <= 1'b0;
            overrun <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_det <= 1'b0;
`endif

            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            // Frame completion, one cycle after the final stop decision.
            if (done_q) begin
`ifdef UART_RX_BREAK_DET_EN
                if (brk_q) begin
                    break_det <= 1'b1;
                end else
`endif
                if (par_bad_q || stp_bad_q) begin
                    par_err <= par_bad_q;
                    stp_err <= stp_bad_q;
                end else if (!data_valid || data_ready) begin
                    P_DATA     <= shift_q;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end

            if (at_s1) s1_q <= rx_s;
            if (at_s2) s2_q <= rx_s;

            if (state_q inside {StStart, StData, StParity, StStop1, StStop2}) begin
                edge_cnt_q <= at_end ? '0 : edge_cnt_q + PRESCALE_W'(1);
            end

            case (state_q)
                // Level-sensitive so a line still low after a failed frame re-arms at once.
                StIdle: begin
                    if (!rx_s) begin
                        state_q    <= StStart;
                        busy       <= 1'b1;
                        edge_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        presc_q    <= presc_in;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        stop2_q    <= STOP2;
                        par_bad_q  <= 1'b0;
                        stp_bad_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                        all_zero_q <= 1'b1;
                        brk_q      <= 1'b0;
`endif
                    end
                end
                StStart: begin
                    if (at_s3 && maj) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else if (at_end) begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (at_s3) begin
                        shift_q <= {maj, shift_q[DATA_W-1:1]};
`ifdef UART_RX_BREAK_DET_EN
                        if (maj) all_zero_q <= 1'b0;
`endif
                    end
                    if (at_end) begin
                        bit_cnt_q <= bit_cnt_q + BitCntW'(1);
                        if (bit_cnt_q == LastBit) begin
                            state_q <= par_en_q ? StParity : StStop1;
                        end
                    end
                end
                StParity: begin
                    if (at_s3) begin
                        if (maj != (^shift_q ^ par_typ_q)) par_bad_q <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                        if (maj) all_zero_q <= 1'b0;
`endif
                    end
                    if (at_end) begin
                        state_q <= StStop1;
                    end
                end
                StStop1: begin
                    if (at_s3) begin
                        if (!maj) stp_bad_q <= 1'b1;
                        if (!stop2_q) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end
`ifdef UART_RX_BREAK_DET_EN
                        if (all_zero_q && !maj) begin
                            brk_q      <= 1'b1;
                            done_q     <= 1'b1;
                            state_q    <= StWaitIdle;
                            busy       <= 1'b1;
                            edge_cnt_q <= '0;
                        end
`endif
                    end else if (at_end) begin
                        state_q <= StStop2;
                    end
                end
                StStop2: begin
                    if (at_s3) begin
                        if (!maj) stp_bad_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
`ifdef UART_RX_BREAK_DET_EN
                // Needs one full bit time of continuous idle before re-arming.
                StWaitIdle: begin
                    if (!rx_s) begin
                        edge_cnt_q <= '0;
                    end else if (at_end) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        edge_cnt_q <= edge_cnt_q + PRESCALE_W'(1);
                    end
                end
`endif
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised next-generation UART receiver for the system's UART transceiver path. It adds the following:
- configurable data width and prescale width
- 3-sample majority voting
- optional second stop bit
- explicit error flags and overrun detection
- a single-entry valid/ready output holding register, so the consumer may stall

It sits between the RX_IN pad (after the RX clock-domain mux) and the RX data synchroniser / register-file write path.

Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- PRESCALE_W, 6, width of Prescale port.
- SYNC_STAGES, 2, RX_IN synchroniser flops; legal 2..3.

Ports:
- clk  in  1  receiver oversampling clock
- reset  in  1  asynchronous, active-high reset
- RX_IN  in  1  serial line, idle high
- Prescale  in  PRESCALE_W  oversampling ratio; legal even values 8..2^PRESCALE_W-2
- PAR_EN  in  1  1 = parity bit present
- PAR_TYP  in  1  0 = even, 1 = odd
- STOP2  in  1  1 = two stop bits
- P_DATA  out  DATA_W  received word, LSB = first data bit
- data_valid  out  1  P_DATA holds an unconsumed word
- data_ready  in  1  consumer accepts word when data_valid & data_ready
- par_err  out  1  one-cycle pulse, parity mismatch
- stp_err  out  1  one-cycle pulse, stop bit sampled 0
- overrun  out  1  one-cycle pulse, good frame dropped because holding register full
- break_det  out  1  see Optional Feature
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0; P_DATA all zeros. Reset mid-frame aborts the frame immediately; no flags are produced.
- RX_IN passes through SYNC_STAGES flops before use. The synchroniser resets to 1.
- Config latch: Prescale, PAR_EN, PAR_TYP and STOP2 are latched on the start-edge cycle. Changes mid-frame are ignored.
- Prescale clamp: a latched Prescale < 8 is treated as 8. An odd value has its LSB cleared.
- Counters:
  - edge_cnt runs 0..P-1 per bit, where P = latched prescale, and wraps to 0 at P-1 while advancing the bit.
  - bit_cnt counts data bits 0..DATA_W-1.
- Sampling: samples are taken at edge_cnt = P/2-1, P/2, P/2+1. The bit value is the majority of the three, registered at edge_cnt = P/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE -> START on a synchronised 1->0 transition; edge_cnt = 0.
  - START: majority = 1 -> IDLE (glitch, no flag, no output). Otherwise -> DATA at edge_cnt = P-1.
  - DATA: shift the majority value in LSB-first. After bit DATA_W-1 at edge_cnt = P-1, go to PARITY if PAR_EN, else STOP1.
  - PARITY: expected = XOR(data) ^ PAR_TYP. A mismatch sets the internal error flag. -> STOP1 at edge_cnt = P-1.
  - STOP1: decision at the third sample, not at the end of the bit. If STOP2, go to STOP2 at edge_cnt = P-1. Otherwise, finish at the third sample and return to IDLE on the next cycle, so a start edge arriving in the second half of the stop bit is caught.
  - STOP2: same decision rule as STOP1. A 0 on either stop bit flags stp_err.
- Frame completion happens on the cycle after the final stop decision:
  - Error present: par_err and/or stp_err pulse; the word is discarded; data_valid is unchanged.
  - No error and (!data_valid or data_ready this cycle): P_DATA loads; data_valid = 1 the next cycle.
  - No error and data_valid & !data_ready: overrun pulses; the new word is dropped; the old P_DATA is kept.
- Handshake:
  - data_valid clears on the cycle after data_valid & data_ready, unless a simultaneous load occurs, in which case it stays 1 with the new P_DATA.
  - P_DATA is stable while data_valid = 1 and not accepted.
- Parity: with PAR_EN = 0 there is no parity bit and par_err never asserts.
- Latency: from the first RX_IN low to data_valid = SYNC_STAGES + (1 + DATA_W + PAR_EN + STOP2)·P + P/2 + 3 clocks.

Optional Feature:
Macro UART_RX_BREAK_DET_EN.
- Defined:
  - A frame whose start, data, parity (if present) and first stop bit all sample 0 asserts a break_det pulse instead of stp_err/par_err.
  - The FSM then enters a WAIT_IDLE state until the synchronised RX_IN = 1 for one full bit time (P clocks).
  - The frame is not loaded.
- Undefined:
  - break_det is tied 0.
  - A break is reported as an ordinary stp_err (plus par_err if applicable).
  - The FSM returns to IDLE normally and may immediately re-trigger on the still-low line.

Test Plan:
- P=8, DATA_W=8, PAR_EN=1, PAR_TYP=0, STOP2=0; send 0xA5 with parity 0; data_ready=1 -> data_valid one cycle, P_DATA=0xA5, no error pulses, latency as in Behaviour.
- Same configuration, send 0xA5 with parity bit 1 -> par_err single pulse, data_valid stays 0.
- Hold data_ready=0; send 0x3C then 0xC3 back-to-back -> P_DATA=0x3C held, overrun pulses once at the end of the second frame. Then raise data_ready -> data_valid drops next cycle.
- P=16; 3-clock low glitch on RX_IN while idle -> no output and busy returns to 0 by edge_cnt = 15. Also flip one sample per bit during a frame of 0x5A -> majority voting yields P_DATA=0x5A.
- STOP2=1, second stop bit driven 0 -> stp_err. Also change Prescale from 16 to 8 mid-frame -> frame still decoded at P=16.
- Line held low for 20 bit times: with the macro, one break_det pulse and no re-trigger until 16 high clocks; without it, a stp_err pulse on each ~10-bit retrigger.
